// File: rtl/v6502_pkg.sv
// Shared v6502 definitions: sequencer states, addressing-mode encodings and opcode decode.
// The ADDR_MODE_* encodings are also consumed by address_fsm.
package v6502_pkg;

    typedef enum logic [2:0] {
        StReset,
        StFetch,
        StDecode,
        StAddr,
        StExec
    } seq_state_e;

    localparam logic [2:0] ADDR_MODE_IMP  = 3'd0;
    localparam logic [2:0] ADDR_MODE_IMM  = 3'd1;
    localparam logic [2:0] ADDR_MODE_ZP   = 3'd2;
    localparam logic [2:0] ADDR_MODE_ZPI  = 3'd3;
    localparam logic [2:0] ADDR_MODE_ABS  = 3'd4;
    localparam logic [2:0] ADDR_MODE_ABSI = 3'd5;
    localparam logic [2:0] ADDR_MODE_INDX = 3'd6;
    localparam logic [2:0] ADDR_MODE_INDY = 3'd7;

    localparam logic INDEX_X = 1'b0;
    localparam logic INDEX_Y = 1'b1;

    typedef struct packed {
        logic [2:0] mode;
        logic       index;
    } addr_sel_t;

    // Only group-one opcodes need operand addressing; everything else is implied.
    function automatic addr_sel_t decode_addr_mode(input logic [7:0] opcode);
        addr_sel_t sel;
        sel.mode  = ADDR_MODE_IMP;
        sel.index = INDEX_X;
        if (opcode[1:0] == 2'b01) begin
            case (opcode[4:2])
                3'b000: sel.mode = ADDR_MODE_INDX;
                3'b001: sel.mode = ADDR_MODE_ZP;
                3'b010: sel.mode = ADDR_MODE_IMM;
                3'b011: sel.mode = ADDR_MODE_ABS;
                3'b100: begin
                    sel.mode  = ADDR_MODE_INDY;
                    sel.index = INDEX_Y;
                end
                3'b101: sel.mode = ADDR_MODE_ZPI;
                3'b110: begin
                    sel.mode  = ADDR_MODE_ABSI;
                    sel.index = INDEX_Y;
                end
                default: sel.mode = ADDR_MODE_ABSI;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// v6502 instruction sequencer: fetch, decode, hand operand addressing to address_fsm,
// strobe execute, repeat. An addressing phase that overruns ADDR_TIMEOUT cycles is aborted.
module instr_sequencer
    import v6502_pkg::*;
#(
    parameter int unsigned ADDR_TIMEOUT = 7
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rdy,
    input  logic [7:0] i_data,
    input  logic       i_addr_done,
    output logic       o_addr_start,
    output logic [2:0] o_addr_mode,
    output logic       o_addr_index_reg,
    output logic [7:0] o_ir,
    output logic       o_sync,
    output logic       o_pc_out,
    output logic       o_pc_inc,
    output logic       o_exec,
    output logic [2:0] o_tcycle,
    output logic       o_fault
);

    localparam logic [3:0] TimeoutVal = 4'(ADDR_TIMEOUT);

    seq_state_e state_q, state_d;
    logic [7:0] ir_q;
    logic [3:0] tmo_q, tmo_d;
    logic [2:0] tcycle_q, tcycle_d;
    logic       fault_q, fault_d;
    addr_sel_t  sel;

    assign sel = decode_addr_mode(ir_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ir_q     <= 8'h00;
            tmo_q    <= 4'd0;
            tcycle_q <= 3'd0;
            fault_q  <= 1'b0;
        end else begin
            if (state_q == StFetch && i_rdy) begin
                ir_q <= i_data;
            end
            tmo_q    <= tmo_d;
            tcycle_q <= tcycle_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        fault_d = 1'b0;
        case (state_q)
            StReset:  state_d = StFetch;
            StFetch:  if (i_rdy) state_d = StDecode;
            StDecode: begin
                tmo_d   = 4'd0;
                state_d = (sel.mode == ADDR_MODE_IMP) ? StExec : StAddr;
            end
            StAddr: begin
                // A done in the timeout cycle still completes the instruction.
                if (i_addr_done) begin
                    state_d = StExec;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                    if (tmo_d == TimeoutVal) begin
                        state_d = StFetch;
                        fault_d = 1'b1;
                    end
                end
            end
            StExec:   if (i_rdy) state_d = StFetch;
            default:  state_d = StReset;
        endcase
    end

    always_comb begin
        if (state_d == StFetch) begin
            tcycle_d = 3'd0;
        end else if (tcycle_q == 3'd7) begin
            tcycle_d = 3'd7;
        end else begin
            tcycle_d = tcycle_q + 3'd1;
        end
    end

    always_comb begin
        o_sync           = (state_q == StFetch);
        o_pc_out         = (state_q == StFetch);
        o_pc_inc         = (state_q == StFetch) && i_rdy;
        o_addr_start     = (state_q == StDecode) && (sel.mode != ADDR_MODE_IMP);
        o_exec           = (state_q == StExec) && i_rdy;
        o_addr_mode      = sel.mode;
        o_addr_index_reg = sel.index;
        o_ir             = ir_q;
        o_tcycle         = tcycle_q;
        o_fault          = fault_q;
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a small behavioural stand-in for address_fsm.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rdy;
    logic [7:0] data;
    logic       addr_done;
    logic       addr_start;
    logic [2:0] addr_mode;
    logic       addr_index_reg;
    logic [7:0] ir;
    logic       sync;
    logic       pc_out;
    logic       pc_inc;
    logic       exec;
    logic [2:0] tcycle;
    logic       fault;

    int n_checks = 0;
    int n_fail   = 0;

    instr_sequencer #(.ADDR_TIMEOUT(7)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_rdy            (rdy),
        .i_data           (data),
        .i_addr_done      (addr_done),
        .o_addr_start     (addr_start),
        .o_addr_mode      (addr_mode),
        .o_addr_index_reg (addr_index_reg),
        .o_ir             (ir),
        .o_sync           (sync),
        .o_pc_out         (pc_out),
        .o_pc_inc         (pc_inc),
        .o_exec           (exec),
        .o_tcycle         (tcycle),
        .o_fault          (fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({addr_start, addr_mode, addr_index_reg, ir, sync, pc_out, pc_inc, exec,
                    tcycle, fault});
    endfunction

    // Runs one instruction from a FETCH cycle to the next SYNC with rdy held high.
    // done_n: ADDR cycle in which the model address_fsm reports done (0 = never).
    task automatic run_instr(input string tag, input logic [7:0] op, input int done_n,
                             input logic [2:0] exp_mode, input logic exp_idx,
                             input int exp_period, input int exp_exec_t, input bit exp_fault);
        int   cyc;
        int   starts = 0;
        int   execs = 0;
        int   faults = 0;
        int   incs = 0;
        int   exec_t = -1;
        int   acnt = 0;
        bit   busy = 0;
        bit   unstable = 0;
        logic [2:0] dec_mode = 3'd0;
        logic       dec_idx = 1'b0;
        data = op;
        rdy  = 1'b1;
        for (cyc = 0; cyc <= 40; cyc++) begin
            addr_done = busy && (acnt + 1 == done_n);
            #1;
            if (cyc > 0 && fault) faults++;
            if (cyc > 0 && sync) break;
            if (pc_inc) incs++;
            if (addr_start) starts++;
            if (exec) begin
                execs++;
                exec_t = int'(tcycle);
            end
            if (cyc == 1) begin
                dec_mode = addr_mode;
                dec_idx  = addr_index_reg;
            end
            if (busy && (addr_mode !== dec_mode || addr_index_reg !== dec_idx)) unstable = 1;
            if (busy) begin
                acnt++;
                if (addr_done) busy = 0;
            end
            if (addr_start) begin
                busy = 1;
                acnt = 0;
            end
            next_cycle();
        end
        addr_done = 1'b0;
        check_eq({tag, "_period"}, 32'(cyc), 32'(exp_period));
        check_eq({tag, "_ir"}, 32'(ir), 32'(op));
        check_eq({tag, "_mode"}, 32'(dec_mode), 32'(exp_mode));
        check_eq({tag, "_index"}, 32'(dec_idx), 32'(exp_idx));
        check_eq({tag, "_starts"}, 32'(starts), (exp_mode != 3'd0) ? 32'd1 : 32'd0);
        check_eq({tag, "_stable"}, 32'(unstable), 32'd0);
        check_eq({tag, "_pc_inc"}, 32'(incs), 32'd1);
        check_eq({tag, "_faults"}, 32'(faults), 32'(exp_fault));
        check_eq({tag, "_execs"}, 32'(execs), exp_fault ? 32'd0 : 32'd1);
        if (!exp_fault) check_eq({tag, "_exec_t"}, 32'(exec_t), 32'(exp_exec_t));
        check_eq({tag, "_tcycle0"}, 32'(tcycle), 32'd0);
    endtask

    typedef struct {
        logic [7:0] op;
        logic [2:0] mode;
        logic       idx;
    } mode_vec_t;

    mode_vec_t mode_tbl[5] = '{
        '{8'h01, 3'd6, 1'b0},
        '{8'h05, 3'd2, 1'b0},
        '{8'h11, 3'd7, 1'b1},
        '{8'h15, 3'd3, 1'b0},
        '{8'h1D, 3'd5, 1'b0}
    };

    initial begin
        int cnt;
        rst_n     = 1'b0;
        rdy       = 1'b1;
        data      = 8'hEA;
        addr_done = 1'b0;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check_eq("reset_outs", all_outs(), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        check_eq("release_no_sync", 32'(sync), 32'd0);
        next_cycle();
        check_eq("first_sync", 32'({sync, pc_out, tcycle}), 32'({1'b1, 1'b1, 3'd0}));

        run_instr("nop_ea", 8'hEA, 0, 3'd0, 1'b0, 3, 2, 1'b0);
        run_instr("lda_imm", 8'hA9, 1, 3'd1, 1'b0, 4, 3, 1'b0);
        run_instr("lda_absy", 8'hB9, 2, 3'd5, 1'b1, 5, 4, 1'b0);
        run_instr("abs_tmo", 8'hAD, 0, 3'd4, 1'b0, 9, -1, 1'b1);
        run_instr("done_at_tmo", 8'h6D, 7, 3'd4, 1'b0, 10, 7, 1'b0);
        foreach (mode_tbl[i])
            run_instr($sformatf("mode_%02h", mode_tbl[i].op), mode_tbl[i].op, 1,
                      mode_tbl[i].mode, mode_tbl[i].idx, 4, 3, 1'b0);

        // rdy stalls in FETCH and EXEC; addr_done outside ADDR must be ignored.
        data = 8'h42;
        rdy  = 1'b0;
        addr_done = 1'b1;
        #1;
        check_eq("stall_f0", 32'({sync, pc_inc, ir}), 32'({1'b1, 1'b0, 8'h1D}));
        next_cycle();
        check_eq("stall_f1", 32'({sync, pc_inc, ir, tcycle}), 32'({1'b1, 1'b0, 8'h1D, 3'd0}));
        rdy = 1'b1;
        #1;
        check_eq("stall_f_release", 32'(pc_inc), 32'd1);
        next_cycle();
        rdy = 1'b0;
        #1;
        check_eq("stall_decode", 32'({sync, addr_start, ir, tcycle}),
                 32'({1'b0, 1'b0, 8'h42, 3'd1}));
        next_cycle();
        check_eq("stall_e0", 32'({exec, pc_inc, tcycle}), 32'({1'b0, 1'b0, 3'd2}));
        next_cycle();
        check_eq("stall_e1", 32'({exec, tcycle}), 32'({1'b0, 3'd3}));
        rdy = 1'b1;
        #1;
        check_eq("stall_e_release", 32'(exec), 32'd1);
        next_cycle();
        addr_done = 1'b0;
        check_eq("stall_next_sync", 32'({sync, tcycle, fault}), 32'({1'b1, 3'd0, 1'b0}));

        // Asynchronous reset in the middle of an addressing phase.
        data = 8'hB9;
        next_cycle();
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        #1;
        check_eq("midreset_outs", all_outs(), 32'd0);
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            if (exec || fault || sync) cnt++;
        end
        check_eq("midreset_quiet", 32'(cnt), 32'd0);
        rst_n = 1'b1;
        next_cycle();
        check_eq("midreset_sync", 32'({sync, ir}), 32'({1'b1, 8'h00}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
